inst_encoder: RTL and testbench
===============================

INST_ENCODER -- requirements
Module: inst_encoder

Interface
- REQ-001 SHALL provide `clk`, input, 1: single clock; all state updates on the rising edge.
- REQ-002 SHALL provide `rst_n`, input, 1: synchronous, active-low reset.
- REQ-003 SHALL provide `in_valid`, input, 1: request fields valid.
- REQ-004 SHALL provide `in_ready`, output, 1: encoder can accept a request.
- REQ-005 SHALL provide `fmt`, input, 3: format select; 0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6-7 illegal.
- REQ-006 SHALL provide `opcode`, input, 7: placed in inst[6:0].
- REQ-007 SHALL provide `rd`/`rs1`/`rs2`, input, 5 each: register fields.
- REQ-008 SHALL provide `funct3`, input, 3, and `funct7`, input, 7: function fields.
- REQ-009 SHALL provide `imm`, input, 32: signed immediate value, full-width, not pre-shifted.
- REQ-010 SHALL provide `out_valid`, output, 1: `out_inst`/`out_err` valid.
- REQ-011 SHALL provide `out_ready`, input, 1: consumer accepts the word.
- REQ-012 SHALL provide `out_inst`, output, 32: encoded RV32I instruction word.
- REQ-013 SHALL provide `out_err`, output, 1: the word is a substituted NOP due to an encoding error.
- REQ-014 SHALL provide `err_count`, output, 8: saturating count of accepted erroneous requests.

Function
- REQ-015 SHALL accept a request on any edge where `in_valid && in_ready`; `out_valid` SHALL rise on that same edge if the queue was empty (latency 1 cycle), with no combinational path from `in_*` to `out_*`.
- REQ-016 SHALL buffer encoded words in a 2-entry FIFO, in_ready = (count < 2), depending only on registered count.
- REQ-017 SHALL pop on `out_valid && out_ready`.
- REQ-018 On simultaneous push and pop at count 1, count SHALL stay 1.
- REQ-019 SHALL preserve order; data SHALL be held stable while `out_valid && !out_ready`.
- REQ-020 SHALL use these encodings:
  - R: {funct7, rs2, rs1, funct3, rd, opcode}.
  - I: {imm[11:0], rs1, funct3, rd, opcode}.
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
  - U: {imm[31:12], rd, opcode}.
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
- REQ-021 SHALL flag an error when any of these holds:
  - I/S imm outside [-2048, 2047].
  - B imm outside [-4096, 4094] or imm[0]=1.
  - U imm[11:0]≠0.
  - J imm outside [-1048576, 1048574] or imm[0]=1.
  - fmt ≥ 6.
- REQ-022 R-format SHALL ignore `imm` and never flag an error.
- REQ-023 An erroneous request SHALL still be accepted and queued as out_inst=32'h00000013 with out_err=1.
- REQ-024 `err_count` SHALL increment by 1 on acceptance of each erroneous request and saturate at 255.
- REQ-025 Range checks SHALL be signed 32-bit comparisons.

Reset
- REQ-026 While `rst_n`=0 at an edge, the block SHALL set count=0, out_valid=0, out_inst=32'h0, out_err=0, err_count=0, in_ready=0.
- REQ-027 `in_ready` SHALL be 1 on the first edge after rst_n returns high.
- REQ-028 Reset asserted mid-operation SHALL discard queued words; no partial word SHALL appear afterwards.

Verification
- REQ-029 The bench SHALL cover these directed scenarios:
  - I: fmt=1, opcode=0x13, rd=1, rs1=0, funct3=0, imm=0xFFFFFFFF -> out_inst=0xFFF00093, out_err=0, out_valid one edge after accept.
  - B/U: fmt=3, opcode=0x63, rs1=1, rs2=2, funct3=0, imm=8 -> 0x00208463; then fmt=4, opcode=0x37, rd=5, imm=0x12345000 -> 0x123452B7, in order.
  - Error: fmt=2, imm=2048 -> out_inst=0x00000013, out_err=1, err_count=1; fmt=3, imm=6 (odd/2? no: imm=7) -> second NOP, err_count=2.
  - Backpressure: out_ready=0, offer 3 requests -> 2 accepted, in_ready=0, third held; raise out_ready -> all 3 delivered in order, one per cycle.
  - Reset mid-operation: 2 queued plus err_count=3, rst_n=0 for one edge -> out_valid=0, err_count=0, in_ready=1 next edge, queued words never appear.
  - Saturation: 260 erroneous requests -> err_count=255, holding.

Source files
------------

// File: rtl/inst_encoder.sv
// RV32I instruction encoder: packs request fields into a 32-bit word (or a NOP on
// an encoding error) and queues results in a 2-entry output FIFO.
module inst_encoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic        out_err,
  output logic [7:0]  err_count
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  // Returns {err, inst}; an erroneous request encodes as NOP.
  function automatic logic [32:0] encode(
    input logic [2:0]  f,
    input logic [6:0]  op,
    input logic [4:0]  d,
    input logic [4:0]  s1,
    input logic [4:0]  s2,
    input logic [2:0]  f3,
    input logic [6:0]  f7,
    input logic [31:0] im
  );
    logic signed [31:0] simm;
    logic               err;
    logic [31:0]        inst;
    simm = im;
    err  = 1'b0;
    inst = NOP;
    case (f)
      3'd0: inst = {f7, s2, s1, f3, d, op};
      3'd1: begin
        err  = (simm < -32'sd2048) || (simm > 32'sd2047);
        inst = {im[11:0], s1, f3, d, op};
      end
      3'd2: begin
        err  = (simm < -32'sd2048) || (simm > 32'sd2047);
        inst = {im[11:5], s2, s1, f3, im[4:0], op};
      end
      3'd3: begin
        err  = (simm < -32'sd4096) || (simm > 32'sd4094) || im[0];
        inst = {im[12], im[10:5], s2, s1, f3, im[4:1], im[11], op};
      end
      3'd4: begin
        err  = (im[11:0] != 12'd0);
        inst = {im[31:12], d, op};
      end
      3'd5: begin
        err  = (simm < -32'sd1048576) || (simm > 32'sd1048574) || im[0];
        inst = {im[20], im[10:1], im[11], im[19:12], d, op};
      end
      default: err = 1'b1;
    endcase
    if (err) inst = NOP;
    return {err, inst};
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic        acc, pop;
  logic [1:0]  count, count_next;
  logic [32:0] enc_p0;
  logic [31:0] tail_inst_p1;
  logic        tail_err_p1;

  assign acc       = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_valid = (count != 2'd0);
  assign enc_p0    = encode(fmt, opcode, rd, rs1, rs2, funct3, funct7, imm);

  always_comb begin
    count_next = count;
    if (acc && !pop)      count_next = count + 2'd1;
    else if (!acc && pop) count_next = count - 2'd1;
  end

  // p0 -> p1: head register drives the outputs directly; tail holds the second word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count     <= 2'd0;
      in_ready  <= 1'b0;
      out_inst  <= 32'h0;
      out_err   <= 1'b0;
      err_count <= 8'd0;
    end else begin
      count    <= count_next;
      in_ready <= (count_next < 2'd2);
      if (acc && enc_p0[32]) err_count <= sat_inc(err_count);
      if (acc && ((count == 2'd0) || (count == 2'd1 && pop))) begin
        out_inst <= enc_p0[31:0];
        out_err  <= enc_p0[32];
      end else if (pop && count == 2'd2) begin
        out_inst <= tail_inst_p1;
        out_err  <= tail_err_p1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (acc && count == 2'd1 && !pop) begin
      tail_inst_p1 <= enc_p0[31:0];
      tail_err_p1  <= enc_p0[32];
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Randomized and directed bench for inst_encoder against a queue-based reference model.
module tb_inst_encoder;
  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, out_valid, out_ready, out_err;
  logic [2:0]  fmt, funct3;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm, out_inst;
  logic [7:0]  err_count;

  int total = 0;
  int bad   = 0;

  logic [32:0] mq[$];
  logic        m_ready;
  int          m_errc;

  inst_encoder dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_err(out_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %08h want %08h", tag, obs, exp);
    end
  endtask

  // Encoding rules written as field arithmetic on integers.
  function automatic logic [32:0] model_enc(input int f, input int op, input int d,
                                            input int s1, input int s2, input int f3,
                                            input int f7, input int im);
    bit          e = 0;
    logic [31:0] w = 0;
    int          base;
    base = (s1 << 15) | (f3 << 12) | op;
    case (f)
      0: w = (f7 << 25) | (s2 << 20) | base | (d << 7);
      1: begin
        e = (im < -2048) || (im > 2047);
        w = ((im & 'hFFF) << 20) | base | (d << 7);
      end
      2: begin
        e = (im < -2048) || (im > 2047);
        w = (((im >> 5) & 'h7F) << 25) | (s2 << 20) | base | ((im & 'h1F) << 7);
      end
      3: begin
        e = (im < -4096) || (im > 4094) || (im % 2 != 0);
        w = (((im >> 12) & 1) << 31) | (((im >> 5) & 'h3F) << 25) | (s2 << 20) | base
          | (((im >> 1) & 'hF) << 8) | (((im >> 11) & 1) << 7);
      end
      4: begin
        e = (im & 'hFFF) != 0;
        w = (im & 'hFFFFF000) | (d << 7) | op;
      end
      5: begin
        e = (im < -1048576) || (im > 1048574) || (im % 2 != 0);
        w = (((im >> 20) & 1) << 31) | (((im >> 1) & 'h3FF) << 21) | (((im >> 11) & 1) << 20)
          | (((im >> 12) & 'hFF) << 12) | (d << 7) | op;
      end
      default: e = 1;
    endcase
    if (e) w = 32'h13;
    return {e, w};
  endfunction

  // One clock edge: advance the model with the inputs the DUT sees, then compare.
  task automatic step();
    logic acc, pp;
    logic [32:0] r;
    @(posedge clk);
    if (!rst_n) begin
      mq.delete();
      m_ready = 0;
      m_errc  = 0;
    end else begin
      acc = in_valid && m_ready;
      pp  = (mq.size() > 0) && out_ready;
      if (pp) void'(mq.pop_front());
      if (acc) begin
        r = model_enc(fmt, opcode, rd, rs1, rs2, funct3, funct7, $signed(imm));
        mq.push_back(r);
        if (r[32] && m_errc < 255) m_errc++;
      end
      m_ready = (mq.size() < 2);
    end
    #1;
    chk("out_valid", {31'd0, out_valid}, {31'd0, mq.size() > 0});
    chk("in_ready", {31'd0, in_ready}, {31'd0, m_ready});
    chk("err_count", {24'd0, err_count}, m_errc);
    if (mq.size() > 0) begin
      chk("out_inst", out_inst, mq[0][31:0]);
      chk("out_err", {31'd0, out_err}, {31'd0, mq[0][32]});
    end
  endtask

  task automatic req(input int f, input int op, input int d, input int s1,
                     input int s2, input int f3, input int im);
    in_valid = 1; fmt = f[2:0]; opcode = op[6:0]; rd = d[4:0]; rs1 = s1[4:0];
    rs2 = s2[4:0]; funct3 = f3[2:0]; funct7 = 7'd0; imm = im;
  endtask

  function automatic int pick_imm();
    int edges[14] = '{-2049, -2048, 2047, 2048, -4096, 4094, 4096, -4098,
                      -1048576, 1048574, 1048576, 'h12345000, 0, -1};
    case ($urandom_range(0, 3))
      0: return edges[$urandom_range(0, 13)];
      1: return $urandom_range(0, 8191) - 4096;
      2: return int'($urandom) & 'hFFFFF000;
      default: return int'($urandom);
    endcase
  endfunction

  initial begin
    int guard;
    rst_n = 0; in_valid = 0; out_ready = 0;
    fmt = 0; opcode = 0; rd = 0; rs1 = 0; rs2 = 0; funct3 = 0; funct7 = 0; imm = 0;
    m_ready = 0; m_errc = 0;
    step(); step();
    chk("rst_inst", out_inst, 32'h0);
    chk("rst_ready", {31'd0, in_ready}, 32'd0);
    rst_n = 1;
    step();
    chk("ready_after_rst", {31'd0, in_ready}, 32'd1);

    // I-type, latency one edge
    out_ready = 1;
    req(1, 'h13, 1, 0, 0, 0, -1);
    step();
    chk("i_valid", {31'd0, out_valid}, 32'd1);
    chk("i_inst", out_inst, 32'hFFF00093);
    in_valid = 0;
    step();

    // B then U, in order
    out_ready = 0;
    req(3, 'h63, 0, 1, 2, 0, 8);
    step();
    chk("b_inst", out_inst, 32'h00208463);
    req(4, 'h37, 5, 0, 0, 0, 'h12345000);
    step();
    in_valid = 0; out_ready = 1;
    step();
    chk("u_inst", out_inst, 32'h123452B7);
    step();

    // Error substitution
    req(2, 'h23, 0, 1, 2, 2, 2048);
    step();
    chk("s_err_inst", out_inst, 32'h13);
    chk("s_err_flag", {31'd0, out_err}, 32'd1);
    chk("s_err_cnt", {24'd0, err_count}, 32'd1);
    req(3, 'h63, 0, 1, 2, 0, 7);
    step();
    chk("b_odd_cnt", {24'd0, err_count}, 32'd2);
    in_valid = 0;
    step();

    // Backpressure: third request held until space frees up
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      req(0, 'h33, i + 1, i + 2, i + 3, i, 0);
      funct7 = 7'h20;
      step();
    end
    chk("bp_ready", {31'd0, in_ready}, 32'd0);
    out_ready = 1;
    guard = 0;
    while (mq.size() < 2 && guard < 10) begin step(); guard++; end
    in_valid = 0;
    guard = 0;
    while (mq.size() > 0 && guard < 10) begin step(); guard++; end
    chk("bp_drained", {31'd0, out_valid}, 32'd0);

    // Reset with two queued words and err_count=3
    out_ready = 0;
    req(7, 'h13, 0, 0, 0, 0, 0);
    step();
    req(1, 'h13, 3, 0, 0, 0, 5);
    step();
    in_valid = 0;
    chk("pre_rst_cnt", {24'd0, err_count}, 32'd3);
    rst_n = 0;
    step();
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_cnt", {24'd0, err_count}, 32'd0);
    rst_n = 1; out_ready = 1;
    step();
    chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 4; i++) step();

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      fmt = 3'($urandom_range(0, 7)); opcode = 7'($urandom); rd = 5'($urandom);
      rs1 = 5'($urandom); rs2 = 5'($urandom); funct3 = 3'($urandom);
      funct7 = 7'($urandom); imm = pick_imm();
      step();
    end

    // Saturation
    out_ready = 1;
    rst_n = 0; in_valid = 0;
    step();
    rst_n = 1;
    step();
    req(6, 'h13, 0, 0, 0, 0, 0);
    for (int i = 0; i < 260; i++) step();
    chk("sat_cnt", {24'd0, err_count}, 32'd255);
    for (int i = 0; i < 5; i++) step();
    chk("sat_hold", {24'd0, err_count}, 32'd255);
    in_valid = 0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
